// File: rtl/sliding_window_agg.sv
// Sliding-window aggregator: NUM_BUCKETS rotating time buckets of BUCKET_CYCLES clocks each,
// with a saturating running total answered one clock after an evaluation strobe.
module sliding_window_agg #(
    parameter int DATA_W        = 64,
    parameter int OUT_W         = 64,
    parameter int NUM_BUCKETS   = 2,
    parameter int BUCKET_CYCLES = 10,
    parameter int AGG_MODE      = 0,
    localparam int CB_W = (NUM_BUCKETS > 1) ? $clog2(NUM_BUCKETS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              eval_req,
    output logic [OUT_W-1:0]  win_out,
    output logic              win_valid,
    output logic [CB_W-1:0]   cur_bucket,
    output logic              sat
);

    localparam int TW = (BUCKET_CYCLES > 1) ? $clog2(BUCKET_CYCLES) : 1;
    // Two guard bits so total + c - evicted never wraps before the clamp.
    localparam int W  = ((DATA_W > OUT_W) ? DATA_W : OUT_W) + 2;
    localparam logic signed [W-1:0] MAX_W = $signed({{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [W-1:0] MIN_W = ~MAX_W;

    logic [OUT_W-1:0]     bucket [NUM_BUCKETS];
    logic [OUT_W-1:0]     total;
    logic [TW-1:0]        timer;
    logic                 rotate;
    logic [CB_W-1:0]      nxt_bucket;
    logic signed [W-1:0]  c_w;
    logic signed [W-1:0]  evict_w;
    logic signed [W-1:0]  bucket_sum;
    logic signed [W-1:0]  eval_sum;
    logic signed [W-1:0]  total_sum;

    function automatic logic [OUT_W-1:0] clamp(input logic signed [W-1:0] x);
        if (x > MAX_W) return {1'b0, {(OUT_W-1){1'b1}}};
        if (x < MIN_W) return {1'b1, {(OUT_W-1){1'b0}}};
        return x[OUT_W-1:0];
    endfunction

    function automatic logic clipped(input logic signed [W-1:0] x);
        return (x > MAX_W) || (x < MIN_W);
    endfunction

    always_comb begin
        c_w = '0;
        if (in_valid) begin
            if (AGG_MODE == 1) c_w = {{(W-1){1'b0}}, 1'b1};
            else               c_w = W'($signed(in_data));
        end
        rotate     = (timer == TW'(BUCKET_CYCLES-1));
        nxt_bucket = (cur_bucket == CB_W'(NUM_BUCKETS-1)) ? '0 : cur_bucket + 1'b1;
        evict_w    = '0;
        if (rotate) evict_w = W'($signed(bucket[nxt_bucket]));
        bucket_sum = W'($signed(bucket[cur_bucket])) + c_w;
        eval_sum   = W'($signed(total)) + c_w;
        total_sum  = eval_sum - evict_w;
    end

    // A same-cycle event goes into the outgoing bucket; the entered bucket is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BUCKETS; i++) bucket[i] <= '0;
            total      <= '0;
            timer      <= '0;
            cur_bucket <= '0;
            win_out    <= '0;
            win_valid  <= 1'b0;
            sat        <= 1'b0;
        end else if (en) begin
            win_valid <= eval_req;
            if (eval_req) win_out <= clamp(eval_sum);
            bucket[cur_bucket] <= clamp(bucket_sum);
            total <= clamp(total_sum);
            if (rotate) begin
                timer              <= '0;
                bucket[nxt_bucket] <= '0;
                cur_bucket         <= nxt_bucket;
            end else begin
                timer <= timer + 1'b1;
            end
            if (clipped(bucket_sum) || clipped(total_sum) || (eval_req && clipped(eval_sum)))
                sat <= 1'b1;
        end else begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_window_agg.sv
// Directed bench for sliding_window_agg: sum, count and 8-bit saturating instances share
// one stimulus stream; each scenario checks the instance it targets against hand values.
module tb_sliding_window_agg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, in_valid, eval_req;
    logic [63:0] in_data;

    logic signed [63:0] sum_out, cnt_out;
    logic signed [7:0]  s8_out;
    logic sum_vld, cnt_vld, s8_vld;
    logic sum_sat, cnt_sat, s8_sat;
    logic sum_cb, cnt_cb, s8_cb;

    int n_total = 0;
    int n_bad   = 0;

    sliding_window_agg #(.DATA_W(64), .OUT_W(64), .NUM_BUCKETS(2), .BUCKET_CYCLES(10), .AGG_MODE(0))
    u_sum (.clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
           .eval_req(eval_req), .win_out(sum_out), .win_valid(sum_vld),
           .cur_bucket(sum_cb), .sat(sum_sat));

    sliding_window_agg #(.DATA_W(64), .OUT_W(64), .NUM_BUCKETS(2), .BUCKET_CYCLES(10), .AGG_MODE(1))
    u_cnt (.clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
           .eval_req(eval_req), .win_out(cnt_out), .win_valid(cnt_vld),
           .cur_bucket(cnt_cb), .sat(cnt_sat));

    sliding_window_agg #(.DATA_W(64), .OUT_W(8), .NUM_BUCKETS(2), .BUCKET_CYCLES(10), .AGG_MODE(0))
    u_s8 (.clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
          .eval_req(eval_req), .win_out(s8_out), .win_valid(s8_vld),
          .cur_bucket(s8_cb), .sat(s8_sat));

    typedef struct {
        logic               v;
        logic signed [63:0] d;
        logic               e;
        logic               exp_valid;
        logic               chk;
        logic signed [63:0] exp_sum;
        logic signed [63:0] exp_cnt;
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(logic v, logic signed [63:0] d, logic e, logic chk,
                                logic signed [63:0] es, logic signed [63:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.e = e; r.exp_valid = e;
        r.chk = chk; r.exp_sum = es; r.exp_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic e);
        in_valid = v;
        in_data  = d;
        eval_req = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) cyc(1'b0, 64'd0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; eval_req = 1'b0;

        for (int k = 0; k < 27; k++) vecs[k] = mk(1'b0, 0, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++)  vecs[k] = mk(1'b1, 64'(k+1), 1'b0, 1'b0, 0, 0);
        vecs[5]  = mk(1'b0, 0, 1'b1, 1'b1, 15, 5);
        vecs[6]  = mk(1'b0, 0, 1'b0, 1'b1, 15, 5);
        vecs[19] = mk(1'b0, 0, 1'b1, 1'b1, 15, 5);   // evicting cycle still counts bucket 0
        vecs[20] = mk(1'b0, 0, 1'b1, 1'b1, 0, 0);
        for (int k = 21; k < 25; k++) vecs[k] = mk(1'b1, 64'(k-15), 1'b0, 1'b0, 0, 0);
        vecs[25] = mk(1'b0, 0, 1'b1, 1'b1, 30, 4);
        vecs[26] = mk(1'b1, 1, 1'b1, 1'b1, 31, 5);

        // Sum / eviction / back-to-back table
        do_reset();
        check("reset_win_out", sum_out, 0);
        check("reset_win_valid", sum_vld, 0);
        check("reset_sat", sum_sat, 0);
        for (int k = 0; k < 27; k++) begin
            cyc(vecs[k].v, vecs[k].d, vecs[k].e);
            check($sformatf("vec%0d_valid", k), sum_vld, vecs[k].exp_valid);
            if (vecs[k].chk) begin
                check($sformatf("vec%0d_sum", k), sum_out, vecs[k].exp_sum);
                check($sformatf("vec%0d_cnt", k), cnt_out, vecs[k].exp_cnt);
            end
        end

        // Event on the rotation cycle lands in the outgoing bucket
        do_reset();
        repeat (9) cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 64'd7, 1'b0);
        check("rot_cur_bucket", sum_cb, 1);
        repeat (9) cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("rot_eval10", sum_out, 7);
        check("rot_eval10_valid", sum_vld, 1);
        repeat (9) cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("rot_eval20", sum_out, 0);

        // Count mode and enable freeze
        do_reset();
        cyc(1'b1, -64'sd5, 1'b0);
        cyc(1'b1, 64'd100, 1'b0);
        cyc(1'b1, 64'd0, 1'b0);
        cyc(1'b1, 64'd3, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("cnt_eval", cnt_out, 4);
        check("cnt_sum_signed", sum_out, 98);
        en = 1'b0;
        cyc(1'b1, 64'd50, 1'b1);
        check("en0_valid_a", cnt_vld, 0);
        cyc(1'b1, 64'd50, 1'b1);
        check("en0_valid_b", cnt_vld, 0);
        check("en0_hold_out", cnt_out, 4);
        en = 1'b1;
        cyc(1'b0, 0, 1'b1);
        check("cnt_after_en0", cnt_out, 4);
        check("sum_after_en0", sum_out, 98);
        repeat (3) cyc(1'b0, 0, 1'b0);
        check("timer_held_cb0", cnt_cb, 0);
        cyc(1'b0, 0, 1'b0);
        check("timer_held_cb1", cnt_cb, 1);

        // Saturation on the 8-bit instance
        do_reset();
        cyc(1'b1, 64'd100, 1'b0);
        check("s8_sat_before", s8_sat, 0);
        cyc(1'b1, 64'd100, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("s8_clamp", s8_out, 127);
        check("s8_sat", s8_sat, 1);
        check("sum_no_clamp", sum_out, 200);
        check("sum_no_sat", sum_sat, 0);
        repeat (17) cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 64'd5, 1'b0);
        cyc(1'b0, 0, 1'b1);
        check("s8_after_evict", s8_out, 5);
        check("s8_sat_sticky", s8_sat, 1);

        // Reset in mid-window with every other input active
        repeat (12) cyc(1'b0, 0, 1'b0);
        check("pre_reset_cb", s8_cb, 1);
        rst = 1'b0;
        cyc(1'b1, 64'd50, 1'b1);
        check("rst_s8_out", s8_out, 0);
        check("rst_s8_valid", s8_vld, 0);
        check("rst_s8_sat", s8_sat, 0);
        check("rst_s8_cb", s8_cb, 0);
        check("rst_sum_out", sum_out, 0);
        repeat (2) cyc(1'b1, 64'd50, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 0, 1'b1);
        check("post_rst_eval", sum_out, 0);
        check("post_rst_valid", sum_vld, 1);
        repeat (8) cyc(1'b0, 0, 1'b0);
        check("post_rst_cb0", sum_cb, 0);
        cyc(1'b0, 0, 1'b0);
        check("post_rst_cb1", sum_cb, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
